seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_digit_dec.sv | 23 ++
 rtl/seg7_scan_driver.sv | 96 +++++++++
 tb/tb_seg7_scan_driver.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: active-high segment patterns {a,b,c,d,e,f,g} shared by the scan driver.
package seg7_pkg;
    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_ERR = 7'b0110111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;
endpackage

// File: rtl/seg7_digit_dec.sv
// seg7_digit_dec: combinational BCD to active-high segments; codes 10-15 show the error glyph.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_ERR;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with frame-aligned double buffering.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYC      = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic [DIGITS-1:0]     load_dp,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_IDLE = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_IDLE = {DIGITS{DIG_ACTIVE_LOW}};

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [4*DIGITS-1:0] disp_bcd, pend_bcd;
    logic [DIGITS-1:0] disp_dp, pend_dp;
    logic pend_v, term, frame, lit, blank;
    logic [6:0] dec_seg;

    assign term = presc == PW'(SCAN_DIV - 1);
    assign frame = term && idx == IW'(DIGITS - 1);
    assign lit = enable && presc >= PW'(BLANK_CYC);
    assign load_ready = !pend_v;

`ifdef SEG7_LZ_BLANK_EN
    // lz[i]: digit i and everything above it are zero with no dp
    logic [DIGITS:0] lz;
    assign lz[DIGITS] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++)
        assign lz[i] = lz[i+1] && disp_bcd[4*i +: 4] == 4'd0 && !disp_dp[i];
    assign blank = lz[idx] && idx != '0;
`else
    assign blank = 1'b0;
`endif

    seg7_digit_dec u_dec (
        .bcd(disp_bcd[4*idx +: 4]),
        .seg(dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= (!enable || term) ? '0 : presc + 1'b1;
            idx   <= !enable ? '0 : !term ? idx : frame ? '0 : idx + 1'b1;
        end
    end

    // Display register only changes at a frame boundary or while disabled, so frames never tear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v   <= 1'b0;
            pend_bcd <= '0;
            pend_dp  <= '0;
            disp_bcd <= '0;
            disp_dp  <= '0;
        end else if (load_valid && !pend_v) begin
            pend_v   <= 1'b1;
            pend_bcd <= load_bcd;
            pend_dp  <= load_dp;
        end else if (pend_v && (frame || !enable)) begin
            pend_v   <= 1'b0;
            disp_bcd <= pend_bcd;
            disp_dp  <= pend_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_IDLE;
            dp  <= SEG_ACTIVE_LOW;
            dig <= DIG_IDLE;
        end else begin
            seg <= (lit && !blank ? dec_seg : SEG_OFF) ^ SEG_IDLE;
            dp  <= (lit && !blank && disp_dp[idx]) ^ SEG_ACTIVE_LOW;
            dig <= (lit ? DIGITS'(1) << idx : '0) ^ DIG_IDLE;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: table-driven check of the scanner (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1).
module tb_seg7_scan_driver;
    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, load_valid = 1'b0;
    logic [15:0] load_bcd = '0;
    logic [3:0] load_dp = '0;
    logic load_ready, dp;
    logic [6:0] seg;
    logic [3:0] dig;
    int n_chk = 0, n_fail = 0;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [6:0] Z = 7'b0000000;
`else
    localparam logic [6:0] Z = 7'b1111110;
`endif
    localparam logic [11:0] IDLE = {4'hF, 7'h00, 1'b0};

    typedef struct {
        logic [15:0]      bcd;
        logic [3:0]       dpv;
        logic [3:0][6:0]  seg;
    } vec_t;

    vec_t vecs[6];
    logic [3:0][6:0] prev_seg;
    logic [3:0] prev_dp;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid),
        .load_ready(load_ready), .load_bcd(load_bcd), .load_dp(load_dp),
        .seg(seg), .dp(dp), .dig(dig)
    );

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // k counts cycles from the start of a frame: one blank cycle then three lit per slot
    function automatic logic [11:0] slot_exp(input int k, input logic [3:0][6:0] s, input logic [3:0] d);
        int sl;
        sl = k / 4;
        return (k % 4 == 0) ? IDLE : {~(4'b0001 << sl), s[sl], d[sl]};
    endfunction

    function automatic logic [11:0] old_exp();
        logic [11:0] e;
        e = IDLE;
        for (int i = 0; i < 4; i++)
            if (dig == ~(4'b0001 << i)) e = {dig, prev_seg[i], prev_dp[i]};
        return e;
    endfunction

    task automatic check_frames(input int n, input logic [3:0][6:0] s, input logic [3:0] d);
        for (int k = 0; k < 16 * n; k++) begin
            @(negedge clk);
            chk("scan", {dig, seg, dp}, slot_exp(k % 16, s, d));
        end
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        load_bcd = b;
        load_dp = d;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_xfer();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 48 && !ok; n++) begin
            if (load_ready) ok = 1'b1;
            else begin
                chk("hold_old", {dig, seg, dp}, old_exp());
                @(negedge clk);
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL xfer_timeout: load_ready stayed 0, required 1");
        end
    endtask

    initial begin
        bit found;
        vecs[0] = '{16'h1234, 4'b0000, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
        vecs[1] = '{16'h5678, 4'b0001, {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}};
        vecs[2] = '{16'h00A7, 4'b0000, {Z, Z, 7'b0110111, 7'b1110000}};
        vecs[3] = '{16'h0000, 4'b0000, {Z, Z, Z, 7'b1111110}};
        vecs[4] = '{16'h0900, 4'b1000, {7'b1111110, 7'b1111011, 7'b1111110, 7'b1111110}};
        vecs[5] = '{16'hFEDC, 4'b0110, {7'b0110111, 7'b0110111, 7'b0110111, 7'b0110111}};
        prev_seg = {Z, Z, Z, 7'b1111110};
        prev_dp = 4'b0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", {dig, seg, dp}, IDLE);
        chk("reset_ready", {11'b0, load_ready}, 12'd1);
        rst_n = 1'b1;
        check_frames(1, prev_seg, prev_dp);

        for (int v = 0; v < 6; v++) begin
            do_load(vecs[v].bcd, vecs[v].dpv);
            chk("ready_low", {11'b0, load_ready}, 12'd0);
            wait_xfer();
            check_frames(1, vecs[v].seg, vecs[v].dpv);
            prev_seg = vecs[v].seg;
            prev_dp = vecs[v].dpv;
        end

        // disable while a load is pending: immediate transfer, outputs dark, restart at slot 0
        do_load(16'h4321, 4'b0100);
        enable = 1'b0;
        chk("dis_pending", {11'b0, load_ready}, 12'd0);
        @(negedge clk);
        chk("dis_ready", {11'b0, load_ready}, 12'd1);
        chk("dis_out", {dig, seg, dp}, IDLE);
        repeat (9) begin
            @(negedge clk);
            chk("dis_out", {dig, seg, dp}, IDLE);
        end
        enable = 1'b1;
        check_frames(1, {7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000}, 4'b0100);

        // async reset during slot 2 with a pending value that must be discarded
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (dig == 4'b1011) found = 1'b1;
        end
        chk("slot2_seen", {11'b0, found}, 12'd1);
        do_load(16'h8888, 4'hF);
        chk("rst_pending", {11'b0, load_ready}, 12'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {dig, seg, dp}, IDLE);
        chk("async_rst_ready", {11'b0, load_ready}, 12'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check_frames(2, {Z, Z, Z, 7'b1111110}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
